// File: rtl/shift_reg_ctrl.sv
// Command sequencer driving a WIDTH-bit universal shift register (load/shift/rotate).
// Optional feature macro: SHREG_CTRL_ROTATE_EN (enables ROR/ROL; otherwise they are rejected).
module shift_reg_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_fill,
    input  logic [WIDTH-1:0] sr_q,
    output logic [1:0]       sr_mode,
    output logic             sr_serial_in_r,
    output logic             sr_serial_in_l,
    output logic [WIDTH-1:0] sr_parallel_in,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_SHR  = 3'd1;
    localparam logic [2:0] OP_SHL  = 3'd2;
    localparam logic [2:0] OP_ROR  = 3'd3;
    localparam logic [2:0] OP_ROL  = 3'd4;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic op_legal(input logic [2:0] op);
        logic ok;
        case (op)
            OP_LOAD, OP_SHR, OP_SHL: ok = 1'b1;
`ifdef SHREG_CTRL_ROTATE_EN
            OP_ROR, OP_ROL:          ok = 1'b1;
`endif
            default:                 ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Rotates reuse the plain shift modes; only the serial source differs.
    function automatic logic [1:0] op_mode(input logic [2:0] op);
        logic [1:0] m;
        case (op)
            OP_LOAD:        m = MODE_LOAD;
            OP_SHR, OP_ROR: m = MODE_SHR;
            OP_SHL, OP_ROL: m = MODE_SHL;
            default:        m = MODE_HOLD;
        endcase
        return m;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [2:0]         op_q, op_d;
    logic               fill_q, fill_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [1:0]         mode_q, mode_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   accept_cnt_s;

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        op_d         = op_q;
        fill_d       = fill_q;
        data_d       = data_q;
        mode_d       = mode_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        accept_cnt_s = (cmd_op == OP_LOAD) ? CNT_ONE : cmd_count;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d        = cmd_op;
                    fill_d      = cmd_fill;
                    data_d      = cmd_data;
                    remaining_d = accept_cnt_s;
                    if (op_legal(cmd_op) && (accept_cnt_s != {CNT_W{1'b0}})) begin
                        state_d = ST_EXEC;
                        mode_d  = op_mode(cmd_op);
                    end else begin
                        state_d = ST_DONE;
                        mode_d  = MODE_HOLD;
                        done_d  = 1'b1;
                        err_d   = ~op_legal(cmd_op);
                    end
                end else begin
                    mode_d = MODE_HOLD;
                end
            end
            ST_EXEC: begin
                remaining_d = remaining_q - CNT_ONE;
                if (remaining_q == CNT_ONE) begin
                    state_d = ST_DONE;
                    mode_d  = MODE_HOLD;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                mode_d  = MODE_HOLD;
            end
        endcase
    end

    // State and output registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= ST_IDLE;
            remaining_q <= {CNT_W{1'b0}};
            op_q        <= OP_LOAD;
            fill_q      <= 1'b0;
            data_q      <= {WIDTH{1'b0}};
            mode_q      <= MODE_HOLD;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            op_q        <= op_d;
            fill_q      <= fill_d;
            data_q      <= data_d;
            mode_q      <= mode_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

`ifdef SHREG_CTRL_ROTATE_EN
    // Rotate feedback comes from the live register output so it is never stale.
    always_comb begin
        if (op_q == OP_ROR) begin
            sr_serial_in_r = sr_q[0];
        end else begin
            sr_serial_in_r = fill_q;
        end
        if (op_q == OP_ROL) begin
            sr_serial_in_l = sr_q[WIDTH-1];
        end else begin
            sr_serial_in_l = fill_q;
        end
    end
`else
    logic unused_sr_q_s;
    assign unused_sr_q_s  = ^sr_q;
    assign sr_serial_in_r = fill_q;
    assign sr_serial_in_l = fill_q;
`endif

    assign sr_mode        = mode_q;
    assign sr_parallel_in = data_q;
    assign done           = done_q;
    assign err            = err_q;
    assign busy           = (state_q != ST_IDLE);
    assign cmd_ready      = (state_q == ST_IDLE);

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Randomized self-checking bench for shift_reg_ctrl with a behavioural shift register attached.
module tb_shift_reg_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             clr;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_fill;
    logic [WIDTH-1:0] sr_q = '0;
    logic [1:0]       sr_mode;
    logic             sr_serial_in_r;
    logic             sr_serial_in_l;
    logic [WIDTH-1:0] sr_parallel_in;
    logic             busy;
    logic             done;
    logic             err;

    int n_checks = 0;
    int n_pass   = 0;
    int model_q  = 0;

    shift_reg_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .clr            (clr),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_count      (cmd_count),
        .cmd_data       (cmd_data),
        .cmd_fill       (cmd_fill),
        .sr_q           (sr_q),
        .sr_mode        (sr_mode),
        .sr_serial_in_r (sr_serial_in_r),
        .sr_serial_in_l (sr_serial_in_l),
        .sr_parallel_in (sr_parallel_in),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;

    // The controlled universal shift register.
    always @(posedge clk) begin
        case (sr_mode)
            2'b01:   sr_q <= {sr_serial_in_r, sr_q[WIDTH-1:1]};
            2'b10:   sr_q <= {sr_q[WIDTH-2:0], sr_serial_in_l};
            2'b11:   sr_q <= sr_parallel_in;
            default: sr_q <= sr_q;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Reference: what a command does to the register, computed arithmetically.
    task automatic ref_cmd(input int op, input int cnt, input int fill, input int data,
                           inout int q, output int n_eff, output int exp_err, output int exp_mode);
        int legal;
        int top;
        top = 1 << (WIDTH - 1);
        legal = (op <= 2) ? 1 : 0;
`ifdef SHREG_CTRL_ROTATE_EN
        if (op == 3 || op == 4) legal = 1;
`endif
        exp_err  = legal ? 0 : 1;
        n_eff    = !legal ? 0 : (op == 0) ? 1 : cnt;
        exp_mode = (op == 0) ? 3 : (op == 1 || op == 3) ? 1 : 2;
        for (int i = 0; i < n_eff; i++) begin
            case (op)
                0: q = data;
                1: q = (q >> 1) + (fill * top);
                2: q = ((q * 2) + fill) % (2 * top);
                3: q = (q >> 1) + ((q % 2) * top);
                4: q = ((q * 2) % (2 * top)) + (q / top);
                default: q = q;
            endcase
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
        check_eq("ready_before_cmd", cmd_ready, 1);
    endtask

    task automatic run_cmd(input int op, input int cnt, input int fill, input int data);
        int n_eff, exp_err, exp_mode;
        int mode_cycles, done_cyc, err_seen, first_mode, first_pin;
        wait_ready();
        ref_cmd(op, cnt, fill, data, model_q, n_eff, exp_err, exp_mode);
        cmd_op    = op[2:0];
        cmd_count = cnt[CNT_W-1:0];
        cmd_fill  = fill[0];
        cmd_data  = data[WIDTH-1:0];
        cmd_valid = 1'b1;
        @(posedge clk);
        mode_cycles = 0; done_cyc = 0; err_seen = 0; first_mode = 0; first_pin = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) cmd_valid = 1'b0;
            if (sr_mode != 2'b00) begin
                if (mode_cycles == 0) begin
                    first_mode = sr_mode;
                    first_pin  = sr_parallel_in;
                end
                mode_cycles++;
            end
            if (done) begin
                done_cyc = c;
                err_seen = err;
                check_eq("ready_low_at_done", cmd_ready, 0);
                break;
            end
        end
        check_eq("done_latency", done_cyc, n_eff + 1);
        check_eq("err_flag", err_seen, exp_err);
        check_eq("mode_cycles", mode_cycles, n_eff);
        if (n_eff > 0) check_eq("mode_value", first_mode, exp_mode);
        if (op == 0) check_eq("load_pin", first_pin, data);
        check_eq("sr_q_after", sr_q, model_q);
        @(negedge clk);
        check_eq("done_single_pulse", done, 0);
        check_eq("ready_after_done", cmd_ready, 1);
    endtask

    initial begin
        int ab_n, ab_e, ab_m, done_seen, top;
        clr = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_count = '0; cmd_data = '0; cmd_fill = 1'b0;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        check_eq("rst_mode", sr_mode, 0);
        check_eq("rst_ready", cmd_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_pin", sr_parallel_in, 0);
        check_eq("rst_serials", {sr_serial_in_r, sr_serial_in_l}, 0);

        run_cmd(0, 0, 0, 4'b1010);
        check_eq("load_1010", sr_q, 4'b1010);
        run_cmd(2, 2, 1, 0);
        check_eq("shl2_1011", sr_q, 4'b1011);
        run_cmd(3, 3, 0, 0);
`ifdef SHREG_CTRL_ROTATE_EN
        check_eq("ror3_0111", sr_q, 4'b0111);
`else
        check_eq("ror_rejected_1011", sr_q, 4'b1011);
`endif
        run_cmd(1, 0, 1, 0);
        run_cmd(7, 5, 1, 4'b0110);
        run_cmd(4, 2, 0, 0);

        // Abort SHR count 5 after exactly two shifts.
        wait_ready();
        top = model_q;
        ref_cmd(1, 2, 1, 0, top, ab_n, ab_e, ab_m);
        cmd_op = 3'd1; cmd_count = 4'd5; cmd_fill = 1'b1; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check_eq("abort_mode_pre", sr_mode, 1);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check_eq("abort_mode", sr_mode, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_ready", cmd_ready, 1);
        check_eq("abort_done", done, 0);
        check_eq("abort_pin_serial", {sr_parallel_in, sr_serial_in_r, sr_serial_in_l}, 0);
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check_eq("abort_no_done", done_seen, 0);
        model_q = top;
        check_eq("abort_two_shifts", sr_q, model_q);

        for (int k = 0; k < 60; k++) begin
            run_cmd($urandom_range(0, 7), ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 5),
                    $urandom_range(0, 1), $urandom_range(0, 15));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_reg_ctrl.md
# shift_reg_ctrl

Command sequencer for the team's WIDTH-bit universal shift register (`mode` 00 hold, 01 shift right, 10 shift left, 11 parallel load). It accepts load/shift/rotate commands over a valid/ready handshake and drives the register's `mode`, serial and parallel inputs for exactly the commanded number of cycles, then reports completion. It sits between a host/bus FSM and one shift-register instance, reading the register's `q` back for rotates.

## Interface
- `WIDTH`, default 4: shift register width.
- `CNT_W`, default 4: width of the shift-count field; maximum count is 2^CNT_W-1.
- `clk` in 1: clock; all state changes on the rising edge.
- `clr` in 1: reset; one clock, reset is synchronous and active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: controller idle; accepts when `cmd_valid & cmd_ready` at an edge.
- `cmd_op` in 3: 000 LOAD, 001 SHR, 010 SHL, 011 ROR, 100 ROL, others illegal.
- `cmd_count` in CNT_W: number of shift/rotate cycles; ignored for LOAD.
- `cmd_data` in WIDTH: LOAD value.
- `cmd_fill` in 1: serial fill bit for SHR/SHL.
- `sr_q` in WIDTH: shift register `q` output.
- `sr_mode` out 2: to register `mode`.
- `sr_serial_in_r` out 1: to register `serial_in_r`.
- `sr_serial_in_l` out 1: to register `serial_in_l`.
- `sr_parallel_in` out WIDTH: to register `parallel_in`.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: one-cycle pulse, coincident with `done`, for a rejected op.

## Operation
- Register contract: SHR `q <= {serial_in_r, q[W-1:1]}`; SHL `q <= {q[W-2:0], serial_in_l}`; LOAD `q <= parallel_in`.
- States: IDLE, EXEC, DONE. `cmd_ready` = (state == IDLE).
- IDLE, on accept:
  - Latch op, fill and data. Set `remaining` = count (LOAD: 1).
  - Legal op with `remaining` ≠ 0: go to EXEC, with `sr_mode` registered to the op's mode.
  - Count 0, or illegal op: go to DONE with `sr_mode` = 00; illegal op also sets `err`.
- EXEC: on each edge, decrement `remaining`. When `remaining` == 1, go to DONE and register `sr_mode` = 00.
- DONE: `done` = 1 for one cycle, then IDLE.
- ROR: `sr_serial_in_r` = `sr_q[0]`, combinational from the live `sr_q`.
- ROL: `sr_serial_in_l` = `sr_q[WIDTH-1]`, combinational from the live `sr_q`.
- Otherwise both serial outputs = latched fill. `sr_parallel_in` = latched data.
- Illegal op: accepted, never drives a non-00 mode, `done` and `err` high together.
- `clr` at any time: next state IDLE. Outputs go to `sr_mode` 00, serials 0, `sr_parallel_in` 0, `busy`/`done`/`err` 0, counter 0. No `done` is issued for the aborted command.
- `cmd_valid` while busy is ignored; the requester holds it until ready.

## Timing
- Accept at edge E0.
- Register operates on edges E1..EN (N = count, or 1 for LOAD).
- `done` is high in the cycle after EN; `cmd_ready` returns high after edge EN+1.
- Count 0 / illegal: `done` in the cycle after E0; ready after E1.
- Minimum command-to-command spacing is N+2 cycles.
- `sr_mode` is registered. Serial inputs in rotate modes are combinational from `sr_q`, so no stale bit is fed back.
- Reset values: `cmd_ready` 1, all other outputs 0.

## Configuration
- `SHREG_CTRL_ROTATE_EN` defined: ROR/ROL are legal and behave as above.
- Undefined: ops 011/100 are illegal (`err`+`done`, no register activity). The serial inputs are always the latched fill, and the `sr_q` input is unused.

## Test plan
- `clr` high 2 cycles -> `sr_mode`=00, `cmd_ready`=1, `busy`=`done`=`err`=0.
- LOAD `cmd_data`=1010 -> `sr_mode`=11 for exactly one cycle with `sr_parallel_in`=1010; `sr_q`=1010 after E1; `done` one cycle later; ready after E2.
- SHL count 2, fill 1, from 1010 -> `sr_mode`=10 for two cycles; `sr_q` 0101 then 1011; `done` once.
- ROR count 3 from 1011 with macro -> `sr_q` 1101, 1110, 0111. Without macro -> `err`=`done`=1 after E0, `sr_mode` stays 00, `sr_q` stays 1011.
- SHR count 0 -> `done` after E0, no non-00 mode. Op 111 -> `err`+`done`, `sr_q` unchanged.
- SHR count 5, `clr` asserted after 2 shifts -> IDLE next edge, `sr_mode` 00, no `done`; `sr_q` reflects exactly 2 shifts.
